// File: rtl/gpio_in_capture.sv
// GPIO input capture: synchronises buttons/switches, debounces them on a shared prescaled
// tick, latches rising edges into PEND and raises a masked level interrupt.
module gpio_in_capture #(
    parameter logic [15:0] DB_RESET = 16'd50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  btn_i,
    input  logic [15:0] sw_i,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int unsigned NumIn = 21;

    logic [NumIn-1:0] in_raw;
    logic [NumIn-1:0] sync1_q, sync_q;
    logic [NumIn-1:0] hist0_q, hist1_q;
    logic [NumIn-1:0] db_q, db_d;
    logic [NumIn-1:0] pend_q, pend_d;
    logic [NumIn-1:0] mask_q;
    logic [NumIn-1:0] stable, rise, clr;
    logic [15:0]      dbcfg_q, cnt_q, lim_m1;
    logic             tick, wr_en, irq_q;

    assign in_raw = {sw_i, btn_i};
    assign wr_en  = sel_i & we_i;

    // DBCFG of zero behaves as a limit of one, so the tick fires every cycle.
    assign lim_m1 = (dbcfg_q == 16'd0) ? 16'd0 : dbcfg_q - 16'd1;
    assign tick   = (cnt_q == lim_m1);

    always_comb begin
        stable = ~(sync_q ^ hist0_q) & ~(sync_q ^ hist1_q);
        db_d   = db_q;
        if (tick) begin
            db_d = (stable & sync_q) | (~stable & db_q);
        end
        rise = db_d & ~db_q;
        clr  = '0;
        if (wr_en && (addr_i == 2'd1)) begin
            clr = wdata_i[NumIn-1:0];
        end
        // A fresh rise wins over a coincident write-1-to-clear.
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync_q  <= '0;
            hist0_q <= '0;
            hist1_q <= '0;
            db_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            dbcfg_q <= DB_RESET;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= in_raw;
            sync_q  <= sync1_q;
            if (tick) begin
                hist1_q <= hist0_q;
                hist0_q <= sync_q;
            end
            db_q   <= db_d;
            pend_q <= pend_d;
            irq_q  <= |(pend_q & mask_q);
            if (wr_en && (addr_i == 2'd2)) begin
                mask_q <= wdata_i[NumIn-1:0];
            end
            if (wr_en && (addr_i == 2'd3)) begin
                dbcfg_q <= wdata_i[15:0];
                cnt_q   <= '0;
            end else if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        if (sel_i) begin
            unique case (addr_i)
                2'd0: rdata_o = {11'b0, db_q};
                2'd1: rdata_o = {11'b0, pend_q};
                2'd2: rdata_o = {11'b0, mask_q};
                2'd3: rdata_o = {16'b0, dbcfg_q};
                default: rdata_o = 32'h0;
            endcase
        end
    end

    assign irq_o = irq_q;

endmodule

// File: doc/gpio_in_capture.md
GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
REQ-001 The block SHALL have parameter DB_RESET, default 16'd50000, giving the reset value of the debounce prescale limit.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port btn_i, input, 5 bits: raw, asynchronous button levels.
REQ-005 The block SHALL have port sw_i, input, 16 bits: raw, asynchronous switch levels.
REQ-006 The block SHALL have port sel_i, input, 1 bit: bus select for this peripheral, decoded by MIO_BUS.
REQ-007 The block SHALL have port we_i, input, 1 bit: bus write strobe, qualified by sel_i.
REQ-008 The block SHALL have port addr_i, input, 2 bits: register word offset (bus address bits [3:2]).
REQ-009 The block SHALL have port wdata_i, input, 32 bits: CPU write data.
REQ-010 The block SHALL have port rdata_o, output, 32 bits: register read data returned to the bus.
REQ-011 The block SHALL have port irq_o, output, 1 bit: level interrupt to the CPU.

Function
REQ-012 The input vector in[20:0] SHALL be {sw_i, btn_i}, and each bit SHALL pass through a 2-flop synchronizer to give sync[20:0].
REQ-013 A prescaler SHALL count 0..limit-1 and assert a one-cycle tick when count==limit-1, then wrap to 0.
REQ-014 limit SHALL equal DBCFG[15:0], except that DBCFG==0 SHALL be treated as limit=1 (tick every cycle).
REQ-015 A write to DBCFG SHALL reset the prescaler count to 0 on the same edge.
REQ-016 On each tick, history SHALL shift as hist1<=hist0 and hist0<=sync.
REQ-017 On each tick, for each bit where sync==hist0==hist1, db_state SHALL take sync; otherwise that db_state bit SHALL hold.
REQ-018 On the edge where a db_state bit goes 0->1, the corresponding PEND bit SHALL be set; 1->0 transitions SHALL NOT set PEND.
REQ-019 Register map, by addr_i: 0 STATE (RO) = {11'b0, db_state}; 1 PEND (write-1-to-clear, bits [20:0]); 2 MASK (RW, bits [20:0]); 3 DBCFG (RW, bits [15:0]).
REQ-020 Unused bits of all registers SHALL read 0.
REQ-021 A write SHALL occur only when sel_i && we_i, and writes to STATE SHALL be ignored.
REQ-022 If PEND set and W1C clear hit the same bit on the same edge, set SHALL win.
REQ-023 rdata_o SHALL be combinational (zero-cycle read latency) from addr_i when sel_i=1, and SHALL be 32'h0 when sel_i=0.
REQ-024 irq_o SHALL be a registered version of |(PEND & MASK), asserting one cycle after the contributing PEND or MASK update.
REQ-025 irq_o SHALL stay high until all masked PEND bits are cleared or masked off.
REQ-026 Latency from a stable input change to a db_state update SHALL be at most 2 + 3*limit cycles.

Reset
REQ-027 On rstn=0 the block SHALL immediately clear sync, hist0, hist1, db_state, PEND, MASK, the prescaler, irq_o and rdata_o (rdata_o unless selected), and SHALL set DBCFG=DB_RESET.
REQ-028 A reset asserted mid-debounce SHALL abort all history, and no PEND bit SHALL be set from pre-reset samples.
REQ-029 After reset, an input already high SHALL set its PEND bit once it is debounced, since db_state starts at 0.
REQ-030 Release of rstn SHALL be treated as synchronous to clk by the surrounding system.

Verification
REQ-031 With DBCFG=4 and btn_i[0] held at 1 from a zero state: STATE[0]=1 within 14 cycles, PEND=0x1, irq_o stays 0 while MASK=0.
REQ-032 With DBCFG=4 and btn_i[1] toggling every 3 cycles (glitching): STATE[1] stays 0 and PEND[1] stays 0.
REQ-033 With MASK=0x1F and a btn_i[2] rise debounced: irq_o=1 one cycle after PEND[2]=1; writing PEND=0x4 makes irq_o=0 one cycle later.
REQ-034 A W1C clear coinciding with a new rise on the same bit leaves PEND set and irq_o high.
REQ-035 Writing DBCFG=0 makes tick fire every cycle, and a sw_i[3] change reaches STATE[8] within 5 cycles; DBCFG reads back 0.
REQ-036 Asserting rstn=0 mid-debounce clears everything, leaves DBCFG=DB_RESET and STATE=0, and produces no spurious PEND bit before re-debounce.
